// File: rtl/axis_parity_checker_if.sv
// AXI-Stream link carrying one data stream with valid/ready handshake.
//   tvalid, tdata[DATA_W], tlast : driven by the master
//   tready                       : driven by the slave
interface axis_parity_checker_if #(
  parameter int unsigned DATA_W = 8
);
  logic              tvalid;
  logic [DATA_W-1:0] tdata;
  logic              tlast;
  logic              tready;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axis_parity_checker.sv
// AXI-Stream packet parity checker.
// Accepts one packet on axis_s, XOR-reduces every accepted beat into a running
// parity, and on tlast answers on axis_m with either the ACK sequence
// 0xAB, 0x12, 0xDE (pass) or a single error word: 0xFE (length overflow) or
// 0xFF (parity fail). Responses are zero-extended to DATA_W.
// Ports:
//   a_clk         clock, rising edge
//   axis_aresetn  asynchronous active-low reset
//   axis_s        slave stream (packet under test)
//   axis_m        master stream (response)
//   pkt_done      one-cycle pulse when the last response beat is accepted
//   pkt_err       result of the last checked packet (1 = fail)
//   pkt_cnt, err_cnt  saturating packet / error counters, present only when
//                     PARITY_STATS_EN is defined
module axis_parity_checker #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ODD_PARITY = 0,
  parameter int unsigned MAX_LEN    = 256
) (
  input  logic                         a_clk,
  input  logic                         axis_aresetn,
  axis_parity_checker_if.slave         axis_s,
  axis_parity_checker_if.master        axis_m,
  output logic                         pkt_done,
  output logic                         pkt_err
`ifdef PARITY_STATS_EN
  ,
  output logic [15:0]                  pkt_cnt,
  output logic [15:0]                  err_cnt
`endif
);

  // Counter saturates at MAX_LEN+1, so it must hold that value.
  localparam int unsigned CNT_W   = $clog2(MAX_LEN + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_LEN + 1);
  localparam logic ODD_BIT = (ODD_PARITY != 0);

  localparam logic [DATA_W-1:0] RSP_ACK0 = DATA_W'(8'hAB);
  localparam logic [DATA_W-1:0] RSP_ACK1 = DATA_W'(8'h12);
  localparam logic [DATA_W-1:0] RSP_ACK2 = DATA_W'(8'hDE);
  localparam logic [DATA_W-1:0] RSP_PAR  = DATA_W'(8'hFF);
  localparam logic [DATA_W-1:0] RSP_OVF  = DATA_W'(8'hFE);

  typedef enum logic [1:0] {
    ST_RX     = 2'd0,
    ST_RESP_1 = 2'd1,
    ST_RESP_2 = 2'd2,
    ST_RESP_3 = 2'd3
  } state_t;

  state_t            r_state, w_state;
  logic              r_acc, w_acc;
  logic [CNT_W-1:0]  r_cnt, w_cnt;
  logic              r_ovf, w_ovf;
  logic              r_s_tready, w_s_tready;
  logic              r_m_tvalid, w_m_tvalid;
  logic [DATA_W-1:0] r_m_tdata, w_m_tdata;
  logic              r_m_tlast, w_m_tlast;
  logic              r_pkt_done, w_pkt_done;
  logic              r_pkt_err, w_pkt_err;

  logic w_s_fire, w_m_fire, w_beat_par, w_ovf_next, w_par_fail;

  assign w_s_fire   = axis_s.tvalid & r_s_tready;
  assign w_m_fire   = r_m_tvalid & axis_m.tready;
  assign w_beat_par = ^axis_s.tdata;
  // Overflow includes the beat being accepted right now.
  assign w_ovf_next = r_ovf | (r_cnt == CNT_MAX);
  assign w_par_fail = (r_acc ^ w_beat_par) != ODD_BIT;

  // State and output registers.
  always_ff @(posedge a_clk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      r_state    <= ST_RX;
      r_acc      <= 1'b0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_s_tready <= 1'b0;
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tlast  <= 1'b0;
      r_pkt_done <= 1'b0;
      r_pkt_err  <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_acc      <= w_acc;
      r_cnt      <= w_cnt;
      r_ovf      <= w_ovf;
      r_s_tready <= w_s_tready;
      r_m_tvalid <= w_m_tvalid;
      r_m_tdata  <= w_m_tdata;
      r_m_tlast  <= w_m_tlast;
      r_pkt_done <= w_pkt_done;
      r_pkt_err  <= w_pkt_err;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state    = r_state;
    w_acc      = r_acc;
    w_cnt      = r_cnt;
    w_ovf      = r_ovf;
    w_s_tready = r_s_tready;
    w_m_tvalid = r_m_tvalid;
    w_m_tdata  = r_m_tdata;
    w_m_tlast  = r_m_tlast;
    w_pkt_done = 1'b0;
    w_pkt_err  = r_pkt_err;

    case (r_state)
      ST_RX: begin
        // Raises tready on the first edge after reset release.
        w_s_tready = 1'b1;
        if (w_s_fire) begin
          if (axis_s.tlast) begin
            w_pkt_err  = w_ovf_next | w_par_fail;
            w_acc      = 1'b0;
            w_cnt      = '0;
            w_ovf      = 1'b0;
            w_state    = ST_RESP_1;
            w_s_tready = 1'b0;
            w_m_tvalid = 1'b1;
            if (w_ovf_next) begin
              w_m_tdata = RSP_OVF;
              w_m_tlast = 1'b1;
            end else if (w_par_fail) begin
              w_m_tdata = RSP_PAR;
              w_m_tlast = 1'b1;
            end else begin
              w_m_tdata = RSP_ACK0;
              w_m_tlast = 1'b0;
            end
          end else begin
            w_acc = r_acc ^ w_beat_par;
            if (r_cnt != CNT_SAT) begin
              w_cnt = r_cnt + CNT_W'(1);
            end
            w_ovf = w_ovf_next;
          end
        end
      end
      default: begin
        // Response beats; the error word is a one-beat response in ST_RESP_1.
        if (w_m_fire) begin
          if (r_m_tlast) begin
            w_m_tvalid = 1'b0;
            w_m_tlast  = 1'b0;
            w_m_tdata  = '0;
            w_pkt_done = 1'b1;
            w_s_tready = 1'b1;
            w_state    = ST_RX;
          end else if (r_state == ST_RESP_1) begin
            w_m_tdata = RSP_ACK1;
            w_state   = ST_RESP_2;
          end else begin
            w_m_tdata = RSP_ACK2;
            w_m_tlast = 1'b1;
            w_state   = ST_RESP_3;
          end
        end
      end
    endcase
  end

  assign axis_s.tready = r_s_tready;
  assign axis_m.tvalid = r_m_tvalid;
  assign axis_m.tdata  = r_m_tdata;
  assign axis_m.tlast  = r_m_tlast;
  assign pkt_done      = r_pkt_done;
  assign pkt_err       = r_pkt_err;

`ifdef PARITY_STATS_EN
  logic [15:0] r_pkt_cnt;
  logic [15:0] r_err_cnt;

  // Counters step on the same edge that raises pkt_done; pkt_err is stable then.
  always_ff @(posedge a_clk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      r_pkt_cnt <= '0;
      r_err_cnt <= '0;
    end else if (w_pkt_done) begin
      if (r_pkt_cnt != 16'hFFFF) begin
        r_pkt_cnt <= r_pkt_cnt + 16'd1;
      end
      if (r_pkt_err && (r_err_cnt != 16'hFFFF)) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

  assign pkt_cnt = r_pkt_cnt;
  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_axis_parity_checker.sv
// Bench for axis_parity_checker: two instances (A: 8-bit, even parity,
// MAX_LEN=4; B: 16-bit, odd parity, MAX_LEN=256) share one stimulus path
// selected by `sel`.
module tb_axis_parity_checker;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        sel;
  logic        s_tvalid;
  logic [15:0] s_tdata;
  logic        s_tlast;
  logic        m_tready;

  int n_vec  = 0;
  int n_fail = 0;

  axis_parity_checker_if #(.DATA_W(8))  if_sa ();
  axis_parity_checker_if #(.DATA_W(8))  if_ma ();
  axis_parity_checker_if #(.DATA_W(16)) if_sb ();
  axis_parity_checker_if #(.DATA_W(16)) if_mb ();

  assign if_sa.tvalid = !sel && s_tvalid;
  assign if_sa.tdata  = s_tdata[7:0];
  assign if_sa.tlast  = s_tlast;
  assign if_ma.tready = !sel && m_tready;
  assign if_sb.tvalid = sel && s_tvalid;
  assign if_sb.tdata  = s_tdata;
  assign if_sb.tlast  = s_tlast;
  assign if_mb.tready = sel && m_tready;

  logic a_done, a_err, b_done, b_err;
`ifdef PARITY_STATS_EN
  logic [15:0] a_pkt_cnt, a_err_cnt, b_pkt_cnt, b_err_cnt;
`endif

  axis_parity_checker #(.DATA_W(8), .ODD_PARITY(0), .MAX_LEN(4)) u_dut_a (
    .a_clk(clk), .axis_aresetn(rst_n), .axis_s(if_sa), .axis_m(if_ma),
    .pkt_done(a_done), .pkt_err(a_err)
`ifdef PARITY_STATS_EN
    , .pkt_cnt(a_pkt_cnt), .err_cnt(a_err_cnt)
`endif
  );

  axis_parity_checker #(.DATA_W(16), .ODD_PARITY(1), .MAX_LEN(256)) u_dut_b (
    .a_clk(clk), .axis_aresetn(rst_n), .axis_s(if_sb), .axis_m(if_mb),
    .pkt_done(b_done), .pkt_err(b_err)
`ifdef PARITY_STATS_EN
    , .pkt_cnt(b_pkt_cnt), .err_cnt(b_err_cnt)
`endif
  );

  logic        mon_s_tready, mon_m_tvalid, mon_m_tlast, mon_done, mon_err;
  logic [15:0] mon_m_tdata;
  assign mon_s_tready = sel ? if_sb.tready : if_sa.tready;
  assign mon_m_tvalid = sel ? if_mb.tvalid : if_ma.tvalid;
  assign mon_m_tdata  = sel ? if_mb.tdata  : 16'(if_ma.tdata);
  assign mon_m_tlast  = sel ? if_mb.tlast  : if_ma.tlast;
  assign mon_done     = sel ? b_done : a_done;
  assign mon_err      = sel ? b_err  : a_err;

  logic [15:0] pkt[$];
  logic [15:0] exp_rsp[$];
  logic        exp_err;
  int          exp_pkts[2];
  int          exp_errs[2];

  typedef struct {
    bit          s;
    int          n;
    logic [15:0] d[6];
    logic [15:0] first;
    bit          err;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t sel=%0d)", name, act, exp, $time, sel);
    end
  endtask

  function automatic vec_t mk(input bit s, input logic [15:0] first, input bit err, input int n,
                              input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2,
                              input logic [15:0] d3, input logic [15:0] d4, input logic [15:0] d5);
    vec_t v;
    v.s = s; v.n = n; v.first = first; v.err = err;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3; v.d[4] = d4; v.d[5] = d5;
    return v;
  endfunction

  // Expected response words for a given first word.
  function automatic void set_expect(input logic [15:0] first, input bit err);
    exp_rsp.delete();
    exp_rsp.push_back(first);
    if (first == 16'h00AB) begin
      exp_rsp.push_back(16'h0012);
      exp_rsp.push_back(16'h00DE);
    end
    exp_err = err;
  endfunction

  // Reference model: count total set bits and length, decide the response.
  function automatic void model(input int s);
    int ones = 0;
    int max_len = (s != 0) ? 256 : 4;
    int odd     = (s != 0) ? 1 : 0;
    foreach (pkt[i]) ones += $countones(pkt[i]);
    if (pkt.size() > max_len)  set_expect(16'h00FE, 1'b1);
    else if ((ones % 2) != odd) set_expect(16'h00FF, 1'b1);
    else                        set_expect(16'h00AB, 1'b0);
  endfunction

  task automatic send_pkt();
    int i = 0;
    int cyc = 0;
    while (i < pkt.size()) begin
      @(negedge clk);
      s_tvalid = ($urandom_range(3) != 0);
      s_tdata  = pkt[i];
      s_tlast  = (i == pkt.size() - 1);
      m_tready = 1'($urandom_range(1));
      if (s_tvalid && mon_s_tready) i++;
      cyc++;
      if (cyc > 200) begin
        chk("send_timeout", 32'(i), 32'(pkt.size()));
        break;
      end
    end
  endtask

  task automatic recv_rsp();
    int k = 0;
    int cyc = 0;
    while (k < exp_rsp.size()) begin
      @(negedge clk);
      chk("rsp_valid", 32'(mon_m_tvalid), 32'd1);
      chk("rsp_s_tready_low", 32'(mon_s_tready), 32'd0);
      chk("rsp_done_low", 32'(mon_done), 32'd0);
      chk("rsp_data", 32'(mon_m_tdata), 32'(exp_rsp[k]));
      chk("rsp_last", 32'(mon_m_tlast), 32'(k == exp_rsp.size() - 1));
      chk("rsp_pkt_err", 32'(mon_err), 32'(exp_err));
      // Junk on the slave side must be ignored while responding.
      s_tvalid = 1'($urandom_range(1));
      s_tdata  = 16'($urandom);
      s_tlast  = 1'($urandom_range(1));
      m_tready = ($urandom_range(3) != 0);
      if (mon_m_tvalid && m_tready) k++;
      cyc++;
      if (cyc > 200) begin
        chk("recv_timeout", 32'(k), 32'(exp_rsp.size()));
        break;
      end
    end
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b0;
    chk("pkt_done", 32'(mon_done), 32'd1);
    chk("end_m_tvalid", 32'(mon_m_tvalid), 32'd0);
    chk("end_m_tlast", 32'(mon_m_tlast), 32'd0);
    chk("end_s_tready", 32'(mon_s_tready), 32'd1);
    chk("end_pkt_err", 32'(mon_err), 32'(exp_err));
    exp_pkts[sel]++;
    if (exp_err) exp_errs[sel]++;
    @(negedge clk);
    chk("pkt_done_pulse", 32'(mon_done), 32'd0);
  endtask

  task automatic chk_all_reset();
    chk("rst_outs_a", {26'd0, if_sa.tready, if_ma.tvalid, if_ma.tlast, a_done, a_err, |if_ma.tdata}, 32'd0);
    chk("rst_outs_b", {26'd0, if_sb.tready, if_mb.tvalid, if_mb.tlast, b_done, b_err, |if_mb.tdata}, 32'd0);
`ifdef PARITY_STATS_EN
    chk("rst_stats", {a_pkt_cnt | a_err_cnt, b_pkt_cnt | b_err_cnt}, 32'd0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b0;
    exp_pkts = '{0, 0}; exp_errs = '{0, 0};
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk_all_reset();

    tbl[0] = mk(0, 16'h00AB, 0, 2, 16'h03, 16'h05, 0, 0, 0, 0);
    tbl[1] = mk(0, 16'h00FF, 1, 1, 16'h01, 0, 0, 0, 0, 0);
    tbl[2] = mk(1, 16'h00AB, 0, 1, 16'h01, 0, 0, 0, 0, 0);
    tbl[3] = mk(0, 16'h00FE, 1, 5, 0, 0, 0, 0, 0, 0);
    tbl[4] = mk(0, 16'h00AB, 0, 4, 16'h03, 16'h03, 16'h00, 16'h00, 0, 0);
    tbl[5] = mk(0, 16'h00AB, 0, 1, 16'h0F, 0, 0, 0, 0, 0);
    tbl[6] = mk(0, 16'h00FE, 1, 6, 16'h01, 0, 0, 0, 0, 0);
    tbl[7] = mk(1, 16'h00AB, 0, 2, 16'h8001, 16'h0100, 0, 0, 0, 0);
    tbl[8] = mk(1, 16'h00FF, 1, 1, 16'hFFFF, 0, 0, 0, 0, 0);
    tbl[9] = mk(0, 16'h00FF, 1, 4, 16'h01, 16'h00, 16'h00, 16'h00, 0, 0);

    repeat (3) @(negedge clk);
    chk_all_reset();
    rst_n = 1'b1;
    chk("rel_s_tready_a", 32'(if_sa.tready), 32'd0);
    @(negedge clk);
    chk("rel_s_tready_a1", 32'(if_sa.tready), 32'd1);
    chk("rel_s_tready_b1", 32'(if_sb.tready), 32'd1);

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      sel = tbl[i].s;
      pkt.delete();
      for (int j = 0; j < tbl[i].n; j++) pkt.push_back(tbl[i].d[j]);
      set_expect(tbl[i].first, tbl[i].err);
      send_pkt();
      recv_rsp();
    end

    // Response stall: tdata holds 0x12 while m_tready is low
    sel = 1'b0;
    pkt.delete(); pkt.push_back(16'h03); pkt.push_back(16'h05);
    send_pkt();
    @(negedge clk);
    m_tready = 1'b1; s_tvalid = 1'b0;
    chk("stall_first", 32'(mon_m_tdata), 32'h00AB);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      m_tready = 1'b0; s_tvalid = 1'b1; s_tdata = 16'($urandom); s_tlast = 1'b1;
      chk("stall_data", 32'(mon_m_tdata), 32'h0012);
      chk("stall_valid", 32'(mon_m_tvalid), 32'd1);
      chk("stall_s_tready", 32'(mon_s_tready), 32'd0);
    end
    exp_rsp.delete(); exp_rsp.push_back(16'h0012); exp_rsp.push_back(16'h00DE);
    exp_err = 1'b0;
    recv_rsp();

    // Reset while the second ACK beat is pending
    pkt.delete(); pkt.push_back(16'h0F);
    send_pkt();
    @(negedge clk);
    m_tready = 1'b1; s_tvalid = 1'b0;
    chk("mid_rst_ack0", 32'(mon_m_tdata), 32'h00AB);
    @(negedge clk);
    m_tready = 1'b0;
    chk("mid_rst_ack1", 32'(mon_m_tdata), 32'h0012);
    #2 rst_n = 1'b0;
    #1 chk_all_reset();
    exp_pkts = '{0, 0}; exp_errs = '{0, 0};
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_s_tready", 32'(mon_s_tready), 32'd1);
    chk("post_rst_m_tvalid", 32'(mon_m_tvalid), 32'd0);
    set_expect(16'h00AB, 1'b0);
    send_pkt();
    recv_rsp();

    // Randomized packets against the reference model
    for (int p = 0; p < 40; p++) begin
      int n;
      sel = 1'($urandom_range(1));
      n = $urandom_range(6, 1);
      pkt.delete();
      for (int j = 0; j < n; j++) begin
        logic [15:0] w;
        w = 16'($urandom);
        if (!sel) w = {8'h00, w[7:0]};
        pkt.push_back(w);
      end
      model(int'(sel));
      send_pkt();
      recv_rsp();
    end

`ifdef PARITY_STATS_EN
    chk("stats_pkt_a", 32'(a_pkt_cnt), 32'(exp_pkts[0]));
    chk("stats_err_a", 32'(a_err_cnt), 32'(exp_errs[0]));
    chk("stats_pkt_b", 32'(b_pkt_cnt), 32'(exp_pkts[1]));
    chk("stats_err_b", 32'(b_err_cnt), 32'(exp_errs[1]));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
